// File: rtl/manual_pedal_sequencer.sv
// Command-driven pedal sequencer for the manual drive FSM.
// Takes START/GO_FWD/GO_REV/COAST/STOP commands, drives th/br/cl/rgs until the
// drive FSM reaches the target state, then pulses a response code.
// Optional feature: define SEQ_AUTO_COAST_EN to allow GO_* while MOVING
// (auto coast to STARTED, swap gear, drive again).
module manual_pedal_sequencer #(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    output logic       rsp_valid,
    output logic [1:0] rsp_code,
    input  logic [1:0] state_in,
    output logic       th,
    output logic       br,
    output logic       cl,
    output logic       rgs,
    output logic       busy
);

    localparam logic [2:0] OpStart = 3'd0;
    localparam logic [2:0] OpGoFwd = 3'd1;
    localparam logic [2:0] OpGoRev = 3'd2;
    localparam logic [2:0] OpCoast = 3'd3;
    localparam logic [2:0] OpStop  = 3'd4;

    localparam logic [1:0] DsOff     = 2'b00;
    localparam logic [1:0] DsStarted = 2'b01;
    localparam logic [1:0] DsMoving  = 2'b10;
    localparam logic [1:0] DsStall   = 2'b11;

    localparam logic [1:0] CodeOk      = 2'b00;
    localparam logic [1:0] CodeIllegal = 2'b01;
    localparam logic [1:0] CodeTimeout = 2'b10;
    localparam logic [1:0] CodeStall   = 2'b11;

    localparam logic [CNT_W-1:0] SettleLast  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {StIdle, StCheck, StSetup, StDrive, StResp, StCoast} state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [1:0]       target_q, target_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             th_q, th_d, br_q, br_d, cl_q, cl_d, rgs_q, rgs_d;

    logic       chk_legal, is_go, dir_rev;
    logic [1:0] chk_target;
    logic       pat_th, pat_br, pat_cl;
    logic       auto_match, auto_coast, setup_stall;

    // Decode the latched op: legality, target state, drive pedal pattern
    always_comb begin
        chk_legal   = 1'b0;
        chk_target  = DsOff;
        pat_th      = 1'b0;
        pat_br      = 1'b0;
        pat_cl      = 1'b1;
        is_go       = (op_q == OpGoFwd) || (op_q == OpGoRev);
        dir_rev     = (op_q == OpGoRev);
        auto_match  = 1'b0;
        auto_coast  = 1'b0;
        setup_stall = 1'b0;
        case (op_q)
            OpStart: begin
                chk_legal  = (state_in == DsOff);
                chk_target = DsStarted;
                pat_th     = 1'b1;
            end
            OpGoFwd, OpGoRev: begin
`ifdef SEQ_AUTO_COAST_EN
                chk_legal  = (state_in == DsStarted) || (state_in == DsMoving);
`else
                chk_legal  = (state_in == DsStarted);
`endif
                chk_target = DsMoving;
                pat_th     = 1'b1;
                pat_cl     = 1'b0;
            end
            OpCoast: begin
                chk_legal  = (state_in == DsMoving);
                chk_target = DsStarted;
            end
            OpStop: begin
                chk_legal  = (state_in == DsStarted) || (state_in == DsMoving);
                chk_target = DsOff;
                pat_br     = 1'b1;
            end
            default: ;
        endcase
`ifdef SEQ_AUTO_COAST_EN
        if (is_go && state_in == DsMoving) begin
            auto_match = (rgs_q == dir_rev);
            auto_coast = (rgs_q != dir_rev);
        end
        setup_stall = (state_in == DsStall);
`endif
    end

    // Sequencer next-state, counter and pedal next values
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        target_d = target_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        th_d     = th_q;
        br_d     = br_q;
        cl_d     = cl_q;
        rgs_d    = rgs_q;
        unique case (state_q)
            StIdle: begin
                // Hold pattern keeps a MOVING car moving, otherwise neutral
                th_d = (state_in == DsMoving);
                br_d = 1'b0;
                cl_d = (state_in != DsMoving);
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                target_d = chk_target;
                if (!chk_legal) begin
                    code_d  = CodeIllegal;
                    state_d = StResp;
                end else if (auto_match) begin
                    code_d  = CodeOk;
                    state_d = StResp;
                end else if (auto_coast) begin
                    th_d    = 1'b0;
                    br_d    = 1'b0;
                    cl_d    = 1'b1;
                    state_d = StCoast;
                end else if (is_go && rgs_q != dir_rev) begin
                    // Gear swap only with clutch in and no throttle
                    th_d    = 1'b0;
                    br_d    = 1'b0;
                    cl_d    = 1'b1;
                    rgs_d   = dir_rev;
                    state_d = StSetup;
                end else begin
                    th_d    = pat_th;
                    br_d    = pat_br;
                    cl_d    = pat_cl;
                    state_d = StDrive;
                end
            end
            StCoast: begin
                if (state_in == DsStarted) begin
                    rgs_d   = dir_rev;
                    state_d = StSetup;
                end else if (state_in == DsStall) begin
                    code_d  = CodeStall;
                    state_d = StResp;
                end else if (cnt_q == TimeoutLast) begin
                    code_d  = CodeTimeout;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StSetup: begin
                if (setup_stall) begin
                    code_d  = CodeStall;
                    state_d = StResp;
                end else if (cnt_q == SettleLast) begin
                    th_d    = pat_th;
                    br_d    = pat_br;
                    cl_d    = pat_cl;
                    state_d = StDrive;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDrive: begin
                // Target match is checked first so it wins over stall/timeout
                if (state_in == target_q) begin
                    code_d  = CodeOk;
                    th_d    = (target_q == DsMoving);
                    br_d    = 1'b0;
                    cl_d    = (target_q != DsMoving);
                    state_d = StResp;
                end else if (state_in == DsStall || cnt_q == TimeoutLast) begin
                    code_d  = (state_in == DsStall) ? CodeStall : CodeTimeout;
                    th_d    = 1'b0;
                    br_d    = 1'b0;
                    cl_d    = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Every phase starts its settle/timeout count from zero
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // State, counter and registered pedal outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= 3'd0;
            target_q <= DsOff;
            code_q   <= CodeOk;
            cnt_q    <= '0;
            th_q     <= 1'b0;
            br_q     <= 1'b0;
            cl_q     <= 1'b1;
            rgs_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            target_q <= target_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            th_q     <= th_d;
            br_q     <= br_d;
            cl_q     <= cl_d;
            rgs_q    <= rgs_d;
        end
    end

    // Handshake and status decode straight from registered state
    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        rsp_valid = (state_q == StResp);
        rsp_code  = code_q;
        th        = th_q;
        br        = br_q;
        cl        = cl_q;
        rgs       = rgs_q;
    end

endmodule
